multicycle_controller: RTL

Sequencing controller for the multicycle RV32I core variant. It reuses one ALU, one unified memory port and the shared immediate extender across several cycles per instruction. It is a Moore FSM plus combinational instruction and ALU decode. It drives every datapath select, write-enable and the 3-bit `immsrc` (000=I, 001=S, 010=B, 011=J, 100=U) consumed by the immediate extender.

---
 rtl/riscv_pkg.sv | 180 ++++++++++++++++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 44 ++++
 rtl/multicycle_controller.sv | 106 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the multicycle RV32I core: controller state
// encoding, opcode constants, datapath mux encodings and the immediate
// format select that the immediate extender also decodes. Keeping the
// immsrc encoding here means the controller and extender cannot drift.
package riscv_pkg;

    // Controller states; encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_EXECUTEU = 4'd11
    } state_t;

    // Major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate format select, shared with the immediate extender.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operand A select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Moore control word held in the output register.
    typedef struct packed {
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic       irwrite;
        logic       pcupdate;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
    } ctrl_t;

    // Immediate format implied by the opcode; unknown opcodes default to I.
    function automatic logic [2:0] imm_for_op(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_LOAD, OP_IALU: imm = IMM_I;
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

    // True for every opcode this controller sequences.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU,
            OP_JAL, OP_BRANCH, OP_LUI, OP_AUIPC: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Control word for a state; anything not listed stays 0, including
    // all enables for the unused encodings.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = {$bits(ctrl_t){1'b0}};
        case (s)
            S_FETCH: begin
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
            end
            S_DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMADR, S_EXECUTEI: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
            end
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
                c.memwrite  = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_RS2;
            end
            S_EXECUTEU: begin
                c.alusrca = SRCA_ZERO;
                c.alusrcb = SRCB_IMM;
            end
            S_ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
            end
            S_JAL: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALUOUT;
                c.pcupdate  = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca   = SRCA_RS1;
                c.alusrcb   = SRCB_RS2;
                c.resultsrc = RES_ALUOUT;
                c.branch    = 1'b1;
            end
            default: c = {$bits(ctrl_t){1'b0}};
        endcase
        return c;
    endfunction

    // Coarse ALU request per state.
    function automatic logic [1:0] state_aluop(input state_t s);
        logic [1:0] aluop;
        case (s)
            S_EXECUTER, S_EXECUTEI: aluop = ALUOP_FUNCT;
            S_BRANCH:               aluop = ALUOP_SUB;
            default:                aluop = ALUOP_ADD;
        endcase
        return aluop;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Bundle between the multicycle datapath and its controller.
//   master (datapath side): drives op, funct3, funct7b5, zero; receives controls.
//   slave  (controller)   : receives instruction fields and zero; drives
//                           immsrc, alusrca, alusrcb, alucontrol, resultsrc,
//                           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    modport master (
        output op, funct3, funct7b5, zero,
        input  immsrc, alusrca, alusrcb, alucontrol, resultsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output immsrc, alusrca, alusrcb, alucontrol, resultsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder
// Turns the FSM's coarse ALU request into a concrete ALU operation.
//   aluop[1:0] in : 00 add, 01 sub, 10 decode from funct fields
//   funct3     in : instruction bits [14:12]
//   op5        in : opcode bit 5 (distinguishes R-type from I-ALU)
//   funct7b5   in : instruction bit 30
//   alucontrol out: ALU operation code
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Operation select; sub only for R-type with bit 30 set, since addi
    // reuses bit 30 as part of its immediate.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 & funct7b5) begin
                            alucontrol = ALU_SUB;
                        end else begin
                            alucontrol = ALU_ADD;
                        end
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the multicycle RV32I core. The Moore controls and the
// ALU operation are registered: they are computed from the next state and
// loaded with it, so each is a function of the current state only.
// Ports:
//   clk   in : rising-edge clock
//   reset in : synchronous, active-high; forces FETCH
//   bus       : multicycle_controller_if.slave (instruction fields, zero in;
//               datapath selects, enables and illegal out)
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    multicycle_controller_if.slave       bus
);

    state_t     state_r;
    state_t     state_next_s;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_next_s;
    logic [1:0] aluop_next_s;
    logic [2:0] alucontrol_next_s;
    logic [2:0] alucontrol_r;

    // Next-state selection; unknown opcodes and unused encodings fall to FETCH.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:  state_next_s = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                    OP_RTYPE:          state_next_s = S_EXECUTER;
                    OP_IALU:           state_next_s = S_EXECUTEI;
                    OP_JAL:            state_next_s = S_JAL;
                    OP_BRANCH:         state_next_s = S_BRANCH;
                    OP_LUI:            state_next_s = S_EXECUTEU;
                    OP_AUIPC:          state_next_s = S_ALUWB;
                    default:           state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // op[5] separates sw (0100011) from lw (0000011).
                if (bus.op[5]) begin
                    state_next_s = S_MEMWRITE;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMREAD:  state_next_s = S_MEMWB;
            S_MEMWB:    state_next_s = S_FETCH;
            S_MEMWRITE: state_next_s = S_FETCH;
            S_EXECUTER: state_next_s = S_ALUWB;
            S_EXECUTEI: state_next_s = S_ALUWB;
            S_EXECUTEU: state_next_s = S_ALUWB;
            S_ALUWB:    state_next_s = S_FETCH;
            S_JAL:      state_next_s = S_ALUWB;
            S_BRANCH:   state_next_s = S_FETCH;
            default:    state_next_s = S_FETCH;
        endcase
    end

    assign ctrl_next_s  = state_ctrl(state_next_s);
    assign aluop_next_s = state_aluop(state_next_s);

    // The instruction register is already loaded when DECODE selects an
    // EXECUTE state, so decoding funct fields one cycle early is safe.
    alu_decoder u_alu_decoder (
        .aluop      (aluop_next_s),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (alucontrol_next_s)
    );

    // State register plus registered Moore outputs; reset parks in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_FETCH;
            ctrl_r       <= state_ctrl(S_FETCH);
            alucontrol_r <= ALU_ADD;
        end else begin
            state_r      <= state_next_s;
            ctrl_r       <= ctrl_next_s;
            alucontrol_r <= alucontrol_next_s;
        end
    end

    assign bus.alusrca    = ctrl_r.alusrca;
    assign bus.alusrcb    = ctrl_r.alusrcb;
    assign bus.resultsrc  = ctrl_r.resultsrc;
    assign bus.adrsrc     = ctrl_r.adrsrc;
    assign bus.irwrite    = ctrl_r.irwrite;
    assign bus.regwrite   = ctrl_r.regwrite;
    assign bus.memwrite   = ctrl_r.memwrite;
    assign bus.alucontrol = alucontrol_r;

    // funct3[0] flips the sense of zero: beq takes on equal, bne on not-equal.
    assign bus.pcwrite = ctrl_r.pcupdate |
                         (ctrl_r.branch & (bus.zero ^ bus.funct3[0]));

    assign bus.immsrc  = imm_for_op(bus.op);
    assign bus.illegal = (state_r == S_DECODE) & ~op_supported(bus.op);

endmodule
